// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcode/funct encodings, ALU operation codes, link register.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/regfile.sv
// 32-entry 2R1W register file, $0 hardwired to zero; reads are combinational with
// same-cycle write-through, writes land on the rising edge; no backpressure.
module regfile #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [4:0]           waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [4:0]           raddr_a,
  input  logic [4:0]           raddr_b,
  output logic [WORD_SIZE-1:0] rdata_a,
  output logic [WORD_SIZE-1:0] rdata_b
);

  logic [WORD_SIZE-1:0] regs_q [32];

  // Contents are deliberately not reset; $0 is never written.
  always_ff @(posedge clk) begin
    if (we && waddr != 5'd0) regs_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_a = regs_q[raddr_a];
    rdata_b = regs_q[raddr_b];
    if (we && waddr == raddr_a) rdata_a = wdata;
    if (we && waddr == raddr_b) rdata_b = wdata;
    if (raddr_a == 5'd0) rdata_a = '0;
    if (raddr_b == 5'd0) rdata_b = '0;
  end

endmodule

// File: rtl/decode.sv
// MIPS ID stage: IF/ID register, regfile, control decode, load-use stall, branch redirect.
// Outputs are combinational one cycle after capture; a load-use stall holds IF/ID and fetch.
module decode import mips_pkg::*; #(
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] BOOT_ADDR = 32'h00000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] if_pc,
  input  logic [31:0]          if_ir,
  output logic                 fetch_load,
  output logic [WORD_SIZE-1:0] fetch_addr,
  input  logic                 wb_we,
  input  logic [4:0]           wb_addr,
  input  logic [WORD_SIZE-1:0] wb_data,
  input  logic                 ex_mem_read,
  input  logic [4:0]           ex_dest,
  output logic                 id_valid,
  output logic [WORD_SIZE-1:0] id_pc,
  output logic [WORD_SIZE-1:0] rs_data,
  output logic [WORD_SIZE-1:0] rt_data,
  output logic [WORD_SIZE-1:0] imm,
  output logic [4:0]           shamt,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           dest,
  output logic [3:0]           alu_op,
  output logic                 alu_src_imm,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 link,
  output logic                 illegal
);

  logic                 valid_q, valid_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [31:0]          ir_q, ir_d;
  logic                 stall, en, taken, eq;
  logic [5:0]           op, funct;
  logic [4:0]           rd;
  logic [3:0]           c_alu;
  logic c_src, c_rw, c_mr, c_mw, c_ill, c_rd_rt, c_zext, c_lui, c_dst_rd;
  logic is_beq, is_bne, is_j, is_jal, is_jr;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign shamt = ir_q[10:6];
  assign funct = ir_q[5:0];
  assign id_pc = pc_q;

  always_comb begin
    valid_d = 1'b1;
    pc_d    = if_pc;
    ir_d    = if_ir;
    if (stall) begin
      valid_d = valid_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= BOOT_ADDR;
      ir_q    <= 32'h0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  regfile #(.WORD_SIZE(WORD_SIZE)) u_regfile (
    .clk(clk), .we(wb_we), .waddr(wb_addr), .wdata(wb_data),
    .raddr_a(rs), .raddr_b(rt), .rdata_a(rs_data), .rdata_b(rt_data)
  );

  // Raw decode of the IF/ID instruction, before bubble/stall gating.
  always_comb begin
    c_alu = ALU_ADD; c_src = 1'b0; c_rw = 1'b0; c_mr = 1'b0; c_mw = 1'b0;
    c_ill = 1'b0; c_rd_rt = 1'b0; c_zext = 1'b0; c_lui = 1'b0; c_dst_rd = 1'b0;
    is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0;
    case (op)
      OP_RTYPE: begin
        c_dst_rd = 1'b1; c_rw = 1'b1; c_rd_rt = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: c_alu = ALU_ADD;
          FN_SUB, FN_SUBU: c_alu = ALU_SUB;
          FN_AND:  c_alu = ALU_AND;
          FN_OR:   c_alu = ALU_OR;
          FN_XOR:  c_alu = ALU_XOR;
          FN_NOR:  c_alu = ALU_NOR;
          FN_SLT:  c_alu = ALU_SLT;
          FN_SLTU: c_alu = ALU_SLTU;
          FN_SLL:  c_alu = ALU_SLL;
          FN_SRL:  c_alu = ALU_SRL;
          FN_SRA:  c_alu = ALU_SRA;
          FN_JR:   begin c_rw = 1'b0; c_rd_rt = 1'b0; is_jr = 1'b1; end
          default: begin c_rw = 1'b0; c_ill = 1'b1; end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin c_rw = 1'b1; c_src = 1'b1; end
      OP_SLTI:  begin c_rw = 1'b1; c_src = 1'b1; c_alu = ALU_SLT; end
      OP_SLTIU: begin c_rw = 1'b1; c_src = 1'b1; c_alu = ALU_SLTU; end
      OP_ANDI:  begin c_rw = 1'b1; c_src = 1'b1; c_alu = ALU_AND; c_zext = 1'b1; end
      OP_ORI:   begin c_rw = 1'b1; c_src = 1'b1; c_alu = ALU_OR;  c_zext = 1'b1; end
      OP_XORI:  begin c_rw = 1'b1; c_src = 1'b1; c_alu = ALU_XOR; c_zext = 1'b1; end
      OP_LUI:   begin c_rw = 1'b1; c_src = 1'b1; c_alu = ALU_LUI; c_lui = 1'b1; end
      OP_LW:    begin c_rw = 1'b1; c_src = 1'b1; c_mr = 1'b1; end
      OP_SW:    begin c_src = 1'b1; c_mw = 1'b1; c_rd_rt = 1'b1; end
      OP_BEQ:   begin is_beq = 1'b1; c_rd_rt = 1'b1; c_alu = ALU_SUB; end
      OP_BNE:   begin is_bne = 1'b1; c_rd_rt = 1'b1; c_alu = ALU_SUB; end
      OP_J:     is_j = 1'b1;
      OP_JAL:   begin is_jal = 1'b1; c_rw = 1'b1; end
      default:  c_ill = 1'b1;
    endcase
  end

  always_comb begin
    if (c_lui)       imm = WORD_SIZE'({ir_q[15:0], 16'h0});
    else if (c_zext) imm = {{(WORD_SIZE-16){1'b0}}, ir_q[15:0]};
    else             imm = {{(WORD_SIZE-16){ir_q[15]}}, ir_q[15:0]};
  end

  assign dest = is_jal ? REG_RA : (c_dst_rd ? rd : rt);

  assign stall = valid_q && !rst && ex_mem_read && ex_dest != 5'd0 &&
                 (ex_dest == rs || (ex_dest == rt && c_rd_rt));
  assign en    = valid_q && !stall && !rst;

  assign id_valid    = en;
  assign alu_op      = en ? c_alu : 4'd0;
  assign alu_src_imm = en && c_src;
  assign reg_write   = en && c_rw;
  assign mem_read    = en && c_mr;
  assign mem_write   = en && c_mw;
  assign link        = en && is_jal;
  assign illegal     = en && c_ill;

  assign eq    = (rs_data == rt_data);
  assign taken = en && ((is_beq && eq) || (is_bne && !eq) || is_j || is_jal || is_jr);

  always_comb begin
    fetch_load = stall;
    fetch_addr = if_pc;
    if (taken) begin
      fetch_load = 1'b1;
      if (is_jr)              fetch_addr = rs_data;
      else if (is_j || is_jal) fetch_addr = {pc_q[WORD_SIZE-1:26], ir_q[25:0]};
      else fetch_addr = pc_q + WORD_SIZE'(1) + {{(WORD_SIZE-16){ir_q[15]}}, ir_q[15:0]};
    end
  end

endmodule

// File: tb/tb_decode.sv
// Directed vector bench for decode: table of single-instruction decodes plus sequences
// for write-through, load-use stall, JR and reset.
module tb_decode;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, if_ir, fetch_addr, wb_data, id_pc, rs_data, rt_data, imm;
  logic        fetch_load, wb_we, ex_mem_read, id_valid;
  logic [4:0]  wb_addr, ex_dest, shamt, rs, rt, dest;
  logic [3:0]  alu_op;
  logic        alu_src_imm, reg_write, mem_read, mem_write, link, illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_ir(if_ir),
    .fetch_load(fetch_load), .fetch_addr(fetch_addr),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
    .id_valid(id_valid), .id_pc(id_pc), .rs_data(rs_data), .rt_data(rt_data),
    .imm(imm), .shamt(shamt), .rs(rs), .rt(rt), .dest(dest), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .link(link), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic        fl;
    logic [31:0] fa;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        cd;
    logic [10:0] ctl;  // {vld, src, rw, mr, mw, lnk, ill, alu[3:0]}
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ir, input logic [31:0] pc, input logic fl,
                              input logic [31:0] fa, input logic [31:0] im,
                              input logic [4:0] d, input logic cd, input logic [6:0] flags,
                              input logic [3:0] alu);
    vec_t v;
    v.ir = ir; v.pc = pc; v.fl = fl; v.fa = fa; v.imm = im; v.dest = d; v.cd = cd;
    v.ctl = {flags, alu};
    return v;
  endfunction

  function automatic logic [10:0] act_ctl();
    return {id_valid, alu_src_imm, reg_write, mem_read, mem_write, link, illegal, alu_op};
  endfunction

  initial begin
    // flags = {vld, src, rw, mr, mw, lnk, ill}
    vecs[0]  = mk(32'h20010005, 32'd0,  0, 0, 32'h5,        5'd1,  1, 7'b1110000, ALU_ADD);
    vecs[1]  = mk(32'h3022FFFF, 32'd1,  0, 0, 32'h0000FFFF, 5'd2,  1, 7'b1110000, ALU_AND);
    vecs[2]  = mk(32'h3C031234, 32'd2,  0, 0, 32'h12340000, 5'd3,  1, 7'b1110000, ALU_LUI);
    vecs[3]  = mk(32'h2404FFFF, 32'd3,  0, 0, 32'hFFFFFFFF, 5'd4,  1, 7'b1110000, ALU_ADD);
    vecs[4]  = mk(32'h8C250008, 32'd4,  0, 0, 32'h8,        5'd5,  1, 7'b1111000, ALU_ADD);
    vecs[5]  = mk(32'hAC25FFFC, 32'd5,  0, 0, 32'hFFFFFFFC, 5'd5,  0, 7'b1100100, ALU_ADD);
    vecs[6]  = mk(32'h00223022, 32'd6,  0, 0, 32'h00003022, 5'd6,  1, 7'b1010000, ALU_SUB);
    vecs[7]  = mk(32'h000238C3, 32'd7,  0, 0, 32'h000038C3, 5'd7,  1, 7'b1010000, ALU_SRA);
    vecs[8]  = mk(32'h0022402B, 32'd8,  0, 0, 32'h0000402B, 5'd8,  1, 7'b1010000, ALU_SLTU);
    vecs[9]  = mk(32'hFC000000, 32'd9,  0, 0, 32'h0,        5'd0,  0, 7'b1000001, ALU_ADD);
    vecs[10] = mk(32'h0000003F, 32'd20, 0, 0, 32'h3F,       5'd0,  0, 7'b1000001, ALU_ADD);
    vecs[11] = mk(32'h14210004, 32'd21, 0, 0, 32'h4,        5'd1,  0, 7'b1000000, ALU_SUB);
    vecs[12] = mk(32'h1021FFFD, 32'd10, 1, 32'd8, 32'hFFFFFFFD, 5'd1, 0, 7'b1000000, ALU_SUB);
    vecs[13] = mk(32'h34098000, 32'd11, 0, 0, 32'h00008000, 5'd9,  1, 7'b1110000, ALU_OR);
    vecs[14] = mk(32'h0C000040, 32'h04000005, 1, 32'h04000040, 32'h40, 5'd31, 1, 7'b1010010, ALU_ADD);
    vecs[15] = mk(32'h08123456, 32'h08000000, 1, 32'h08123456, 32'h3456, 5'd0, 0, 7'b1000000, ALU_ADD);
    vecs[16] = mk(32'h00000000, 32'd40, 0, 0, 32'h0,        5'd0,  1, 7'b1010000, ALU_SLL);
    vecs[17] = mk(32'h2C4AFFFF, 32'd41, 0, 0, 32'hFFFFFFFF, 5'd10, 1, 7'b1110000, ALU_SLTU);

    rst = 1'b1; wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    ex_mem_read = 1'b0; ex_dest = 5'd0;
    if_ir = 32'h20010005; if_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_fetch_load", {31'h0, fetch_load}, 32'h0);
    chk("rst_ctl", {21'h0, act_ctl()}, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);

    rst = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if_ir = vecs[i].ir;
      if_pc = vecs[i].pc;
      @(posedge clk);
      #1;
      if_pc = vecs[i].pc + 32'd1;
      #1;
      chk($sformatf("v%0d_ctl", i), {21'h0, act_ctl()}, {21'h0, vecs[i].ctl});
      chk($sformatf("v%0d_imm", i), imm, vecs[i].imm);
      chk($sformatf("v%0d_pc", i), id_pc, vecs[i].pc);
      chk($sformatf("v%0d_fl", i), {31'h0, fetch_load}, {31'h0, vecs[i].fl});
      if (vecs[i].fl) chk($sformatf("v%0d_fa", i), fetch_addr, vecs[i].fa);
      if (vecs[i].cd) chk($sformatf("v%0d_dest", i), {27'h0, dest}, {27'h0, vecs[i].dest});
    end

    // Write-through: ADD $4,$3,$0 with a same-cycle write of $3.
    if_ir = 32'h00602020; if_pc = 32'd60;
    @(posedge clk); #1;
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD;
    #1;
    chk("wt_rs_bypass", rs_data, 32'hDEAD);
    @(posedge clk); #1;
    wb_addr = 5'd0; wb_data = 32'hFFFF;
    #1;
    chk("wt_rs_stored", rs_data, 32'hDEAD);
    chk("wt_r0_bypass", rt_data, 32'h0);
    @(posedge clk); #1;
    wb_we = 1'b0;
    #1;
    chk("wt_r0_stored", rt_data, 32'h0);

    // Load-use stall on ADD $5,$2,$1.
    if_ir = 32'h00412820; if_pc = 32'd50;
    @(posedge clk); #1;
    if_ir = 32'h20010005; if_pc = 32'd51;
    ex_mem_read = 1'b1; ex_dest = 5'd2;
    #1;
    chk("st_fetch_load", {31'h0, fetch_load}, 32'h1);
    chk("st_fetch_addr", fetch_addr, 32'd51);
    chk("st_id_valid", {31'h0, id_valid}, 32'h0);
    chk("st_reg_write", {31'h0, reg_write}, 32'h0);
    @(posedge clk); #1;
    chk("st_hold_pc", id_pc, 32'd50);
    ex_dest = 5'd1;
    #1;
    chk("st_rt_dep", {31'h0, fetch_load}, 32'h1);
    ex_dest = 5'd0;
    #1;
    chk("st_dest0", {31'h0, id_valid}, 32'h1);
    ex_mem_read = 1'b0; ex_dest = 5'd2;
    #1;
    chk("st_issue_valid", {31'h0, id_valid}, 32'h1);
    chk("st_issue_rw", {31'h0, reg_write}, 32'h1);
    chk("st_issue_dest", {27'h0, dest}, 32'd5);
    chk("st_issue_fl", {31'h0, fetch_load}, 32'h0);
    @(posedge clk); #1;
    chk("st_next_pc", id_pc, 32'd51);

    // JR $31 after writing $31, then with write-through of $31.
    wb_we = 1'b1; wb_addr = 5'd31; wb_data = 32'h1234;
    if_ir = 32'h03E00008; if_pc = 32'd70;
    @(posedge clk); #1;
    wb_we = 1'b0;
    #1;
    chk("jr_fl", {31'h0, fetch_load}, 32'h1);
    chk("jr_fa", fetch_addr, 32'h1234);
    chk("jr_rw", {31'h0, reg_write}, 32'h0);
    wb_we = 1'b1; wb_data = 32'h5678;
    #1;
    chk("jr_fa_wt", fetch_addr, 32'h5678);
    wb_we = 1'b0;

    // Reset asserted while stalled.
    if_ir = 32'h00412820; if_pc = 32'd80;
    @(posedge clk); #1;
    ex_mem_read = 1'b1; ex_dest = 5'd2; if_pc = 32'd81;
    #1;
    chk("rs_stalled", {31'h0, fetch_load}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rs_fl_drop", {31'h0, fetch_load}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; ex_mem_read = 1'b0;
    #1;
    chk("rs_id_valid", {31'h0, id_valid}, 32'h0);
    chk("rs_id_pc", id_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
